// File: rtl/wallace_acc_pkg.sv
// Shared types and default sizing for the Wallace product accumulator.
package wallace_acc_pkg;

  // Two-state control: collecting products, or holding a finished result.
  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 8;

  // Value at which the product counter stops incrementing (default width).
  localparam int CNT_MAX = (1 << DEF_CNT_W) - 1;

endpackage

// File: rtl/wallace_acc_adder.sv
// Ripple-carry adder used by the accumulator; the final carry flags a wrap.

// Single full-adder cell.
module one_bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// ACC_W-bit ripple chain of full-adder cells, carry-in tied low.
module wallace_acc_adder #(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);
  logic [ACC_W:0] carry;

  assign carry[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_fa
      one_bit_full_adder u_fa (
        .a    (a[gi]),
        .b    (b[gi]),
        .cin  (carry[gi]),
        .s    (sum[gi]),
        .cout (carry[gi+1])
      );
    end
  endgenerate

  assign cout = carry[ACC_W];
endmodule

// File: rtl/wallace_product_accumulator.sv
// Sums runs of products from the Wallace reduction tree and hands each run
// total, product count and sticky wrap flag downstream over valid/ready.
module wallace_product_accumulator
  import wallace_acc_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  input  logic              prod_last,
  output logic              prod_ready,
  input  logic              acc_clr,
  output logic [ACC_W-1:0]  acc_sum,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf,
  output logic              acc_valid,
  input  logic              acc_ready
);

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] acc_sum_q, acc_sum_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             acc_valid_q, acc_valid_d;

  logic             prod_hs;
  logic [ACC_W-1:0] add_a, add_b, add_sum;
  logic             add_cout;
  logic [CNT_W-1:0] base_cnt, new_cnt;
  logic             new_ovf;

  // Ready depends only on registered state, never on the downstream ready.
  assign prod_ready = (state_q == ACCUM) && !rst;
  assign prod_hs    = prod_valid && prod_ready;

  // A flush in the same cycle as a product restarts the run at that product.
  assign add_a = acc_clr ? '0 : sum_q;
  assign add_b = {{(ACC_W-PROD_W){1'b0}}, prod};

  wallace_acc_adder #(.ACC_W(ACC_W)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Next-state, working-register and result-register update decisions.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    acc_sum_d   = acc_sum_q;
    acc_cnt_d   = acc_cnt_q;
    acc_ovf_d   = acc_ovf_q;
    acc_valid_d = acc_valid_q;

    base_cnt = acc_clr ? '0 : cnt_q;
    new_cnt  = (base_cnt == CNT_SAT) ? CNT_SAT : base_cnt + CNT_W'(1);
    new_ovf  = (acc_clr ? 1'b0 : ovf_q) | add_cout;

    case (state_q)
      ACCUM: begin
        if (prod_hs) begin
          if (prod_last) begin
            acc_sum_d   = add_sum;
            acc_cnt_d   = new_cnt;
            acc_ovf_d   = new_ovf;
            acc_valid_d = 1'b1;
            state_d     = HOLD;
            sum_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
          end else begin
            sum_d = add_sum;
            cnt_d = new_cnt;
            ovf_d = new_ovf;
          end
        end else if (acc_clr) begin
          sum_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end
      end
      HOLD: begin
        // A flush drops the pending result without a handshake.
        if (acc_clr || (acc_valid_q && acc_ready)) begin
          acc_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and data registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_sum_q   <= '0;
      acc_cnt_q   <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      acc_sum_q   <= acc_sum_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_ovf_q   <= acc_ovf_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign acc_sum   = acc_sum_q;
  assign acc_count = acc_cnt_q;
  assign acc_ovf   = acc_ovf_q;
  assign acc_valid = acc_valid_q;

endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Directed bench: expected results go into a scoreboard queue as stimulus is
// issued; a monitor pops and compares on every result handshake.
module tb_wallace_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] prod = '0;
  logic        prod_valid = 1'b0;
  logic        prod_last = 1'b0;
  logic        prod_ready;
  logic        acc_clr = 1'b0;
  logic [23:0] acc_sum;
  logic [7:0]  acc_count;
  logic        acc_ovf;
  logic        acc_valid;
  logic        acc_ready = 1'b1;

  typedef struct {
    logic [23:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [23:0] hold_sum;
  logic [7:0]  hold_cnt;
  logic        hold_ovf;

  wallace_product_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_last  (prod_last),
    .prod_ready (prod_ready),
    .acc_clr    (acc_clr),
    .acc_sum    (acc_sum),
    .acc_count  (acc_count),
    .acc_ovf    (acc_ovf),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic push_exp(input logic [23:0] s, input logic [7:0] c, input logic o);
    exp_t e;
    e.sum = s; e.cnt = c; e.ovf = o;
    sb_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic drive_prod(input logic [15:0] p, input logic last, input logic clr);
    int guard;
    guard = 0;
    prod = p; prod_valid = 1'b1; prod_last = last; acc_clr = clr;
    @(negedge clk);
    while (!prod_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL prod_ready_timeout: got 0, required 1");
    end
    @(posedge clk); #1;
    prod_valid = 1'b0; prod_last = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: one line per result handshake, compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && acc_valid && acc_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_result: got sum %0d, required no result", acc_sum);
      end else begin
        mon_e = sb_q.pop_front();
        $display("result: sum=%0d count=%0d ovf=%0d", acc_sum, acc_count, acc_ovf);
        check("res_sum", 32'(acc_sum), 32'(mon_e.sum));
        check("res_count", 32'(acc_count), 32'(mon_e.cnt));
        check("res_ovf", 32'(acc_ovf), 32'(mon_e.ovf));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check("rst_prod_ready", 32'(prod_ready), 32'd0);
    check("rst_acc_valid", 32'(acc_valid), 32'd0);
    check("rst_acc_sum", 32'(acc_sum), 32'd0);
    check("rst_acc_count", 32'(acc_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(prod_ready), 32'd1);
    @(posedge clk); #1;

    // Basic run: 100+200+300 = 600, one bubble on prod_ready
    acc_ready = 1'b1;
    push_exp(24'd600, 8'd3, 1'b0);
    drive_prod(16'd100, 1'b0, 1'b0);
    drive_prod(16'd200, 1'b0, 1'b0);
    drive_prod(16'd300, 1'b1, 1'b0);
    @(negedge clk);
    check("bubble_valid", 32'(acc_valid), 32'd1);
    check("bubble_ready_low", 32'(prod_ready), 32'd0);
    @(negedge clk);
    check("bubble_ready_back", 32'(prod_ready), 32'd1);
    check("bubble_valid_clr", 32'(acc_valid), 32'd0);
    @(posedge clk); #1;

    // 256 x 0xFFFF = 16776960 fits in 24 bits; count saturates at 255
    push_exp(24'd16776960, 8'd255, 1'b0);
    for (int i = 0; i < 256; i++) drive_prod(16'hFFFF, (i == 255), 1'b0);
    idle(3);
    // 257 x 0xFFFF = 16842495 -> wraps once to 65279
    push_exp(24'd65279, 8'd255, 1'b1);
    for (int i = 0; i < 257; i++) drive_prod(16'hFFFF, (i == 256), 1'b0);
    idle(3);
    // 258 x 0xFFFF = 16908030 -> 130814, wrapped
    push_exp(24'd130814, 8'd255, 1'b1);
    for (int i = 0; i < 258; i++) drive_prod(16'hFFFF, (i == 257), 1'b0);
    idle(3);

    // Back-pressure: result held stable for 5 cycles
    acc_ready = 1'b0;
    push_exp(24'd11, 8'd1, 1'b0);
    drive_prod(16'd11, 1'b1, 1'b0);
    @(negedge clk);
    hold_sum = acc_sum; hold_cnt = acc_count; hold_ovf = acc_ovf;
    check("hold_first_sum", 32'(hold_sum), 32'd11);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", 32'(acc_valid), 32'd1);
      check("hold_fields", {7'd0, acc_ovf, acc_count, acc_sum[15:0]},
            {7'd0, hold_ovf, hold_cnt, hold_sum[15:0]});
      check("hold_prod_ready", 32'(prod_ready), 32'd0);
    end
    @(posedge clk); #1;
    acc_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("after_hold_ready", 32'(prod_ready), 32'd1);
    @(posedge clk); #1;

    // Flush with a simultaneous last product: result is just that product
    push_exp(24'd7, 8'd1, 1'b0);
    drive_prod(16'd50, 1'b0, 1'b0);
    drive_prod(16'd60, 1'b0, 1'b0);
    drive_prod(16'd7, 1'b1, 1'b1);
    idle(3);

    // Flush while holding: pending result dropped without a handshake
    acc_ready = 1'b0;
    drive_prod(16'd20, 1'b1, 1'b0);
    @(negedge clk);
    check("clr_hold_valid_pre", 32'(acc_valid), 32'd1);
    @(posedge clk); #1;
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    @(negedge clk);
    check("clr_hold_valid_drop", 32'(acc_valid), 32'd0);
    check("clr_hold_ready", 32'(prod_ready), 32'd1);
    @(posedge clk); #1;
    acc_ready = 1'b1;
    push_exp(24'd9, 8'd1, 1'b0);
    drive_prod(16'd9, 1'b1, 1'b0);
    idle(3);

    // Asynchronous reset mid-run
    drive_prod(16'd1, 1'b0, 1'b0);
    drive_prod(16'd2, 1'b0, 1'b0);
    drive_prod(16'd3, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_acc_sum", 32'(acc_sum), 32'd0);
    check("arst_acc_count", 32'(acc_count), 32'd0);
    check("arst_acc_ovf", 32'(acc_ovf), 32'd0);
    check("arst_acc_valid", 32'(acc_valid), 32'd0);
    check("arst_prod_ready", 32'(prod_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("arst_ready_back", 32'(prod_ready), 32'd1);
    @(posedge clk); #1;
    push_exp(24'd5, 8'd1, 1'b0);
    drive_prod(16'd5, 1'b1, 1'b0);
    idle(5);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
